// File: rtl/fifo_rd_packer.sv
// Drains words from a synchronous FIFO and packs PACK of them into one wide word on a valid/ready stream.
// Optional out_parity port when FIFO_RD_PACKER_PARITY_EN is defined.
module fifo_rd_packer #(
    parameter  int DATA_W = 4,
    parameter  int PACK   = 4,
    localparam int CNT_W  = $clog2(PACK + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     fifo_rd_ena,
    input  logic                     fifo_empty,
    input  logic [DATA_W-1:0]        fifo_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PACK*DATA_W-1:0]   out_data,
`ifdef FIFO_RD_PACKER_PARITY_EN
    output logic                     out_parity,
`endif
    output logic [CNT_W-1:0]         out_cnt
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     rd_pend_q, rd_pend_d;
    logic                     flush_req_q, flush_req_d;
    logic [PACK*DATA_W-1:0]   lanes_q, lanes_d;
    logic                     out_valid_q, out_valid_d;
    logic [PACK*DATA_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]         out_cnt_q, out_cnt_d;
    logic                     out_parity_q, out_parity_d;

    logic [CNT_W-1:0]         cnt_cap;
    logic [PACK*DATA_W-1:0]   lanes_cap;
    logic                     out_free;
    logic                     emit_want;

    // Counting the in-flight read keeps back-to-back reads from overfilling the pack.
    always_comb begin
        cnt_cap     = count_q + CNT_W'(rd_pend_q);
        fifo_rd_ena = rstn && !fifo_empty && (state_q == FILL) && !flush_req_q
                      && (cnt_cap < CNT_W'(PACK));
    end

    always_comb begin
        lanes_cap = lanes_q;
        if (rd_pend_q) begin
            lanes_cap[count_q*DATA_W +: DATA_W] = fifo_data;
        end

        out_free  = !out_valid_q || out_ready;
        emit_want = (state_q == HOLD) || (cnt_cap == CNT_W'(PACK))
                    || (flush_req_q && !rd_pend_q && (count_q != '0));

        state_d      = state_q;
        count_d      = cnt_cap;
        lanes_d      = lanes_cap;
        rd_pend_d    = fifo_rd_ena;
        flush_req_d  = flush_req_q || flush;
        out_valid_d  = out_valid_q && !out_ready;
        out_data_d   = out_data_q;
        out_cnt_d    = out_cnt_q;
        out_parity_d = out_parity_q;

        if (emit_want && out_free) begin
            out_data_d   = lanes_cap;
            out_cnt_d    = cnt_cap;
            out_parity_d = ^lanes_cap;
            out_valid_d  = 1'b1;
            count_d      = '0;
            lanes_d      = '0;
            flush_req_d  = 1'b0;
            state_d      = FILL;
        end else if (emit_want) begin
            state_d = HOLD;
        end else if (flush_req_q && !rd_pend_q && (count_q == '0)) begin
            // Flush of an empty pack: nothing to emit, just retire the request.
            flush_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= FILL;
            count_q      <= '0;
            rd_pend_q    <= 1'b0;
            flush_req_q  <= 1'b0;
            lanes_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_cnt_q    <= '0;
            out_parity_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_pend_q    <= rd_pend_d;
            flush_req_q  <= flush_req_d;
            lanes_q      <= lanes_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_cnt_q    <= out_cnt_d;
            out_parity_q <= out_parity_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
`ifdef FIFO_RD_PACKER_PARITY_EN
    assign out_parity = out_parity_q;
`else
    logic unused_parity;
    assign unused_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer (DATA_W=4, PACK=4) with a behavioural FIFO in front.
module tb_fifo_rd_packer;

    localparam int DATA_W = 4;
    localparam int PACK   = 4;
    localparam int CNT_W  = 3;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   fifo_rd_ena;
    logic                   fifo_empty;
    logic [DATA_W-1:0]      fifo_data = '0;
    logic                   flush = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [PACK*DATA_W-1:0] out_data;
    logic [CNT_W-1:0]       out_cnt;
`ifdef FIFO_RD_PACKER_PARITY_EN
    logic                   out_parity;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rd_packer #(.DATA_W(DATA_W), .PACK(PACK)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .fifo_rd_ena (fifo_rd_ena),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
`ifdef FIFO_RD_PACKER_PARITY_EN
        .out_parity  (out_parity),
`endif
        .out_cnt     (out_cnt)
    );

    // Behavioural FIFO: data appears the cycle after an accepted read.
    logic [DATA_W-1:0] fmem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_ena && !fifo_empty) begin
            fifo_data <= fmem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [DATA_W-1:0] v);
        fmem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [15:0] exp_data, input logic [2:0] exp_cnt);
        chk({name, "_data"}, 32'(out_data), 32'(exp_data));
        chk({name, "_cnt"}, 32'(out_cnt), 32'(exp_cnt));
`ifdef FIFO_RD_PACKER_PARITY_EN
        chk({name, "_par"}, 32'(out_parity), 32'(^exp_data));
`endif
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_vld"}, 32'(out_valid), 32'd1);
    endtask

    typedef struct {
        logic        flush;
        logic        rdy;
        logic        exp_rd;
        logic        exp_vld;
        logic [15:0] exp_data;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int base;
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h4321, 3'd4};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0};

        // Reset state with a non-empty FIFO: no read strobe allowed.
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        @(negedge clk);
        #1;
        chk("rst_rd_ena", 32'(fifo_rd_ena), 32'd0);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk_out("rst", 16'h0000, 3'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Full pack streaming through with downstream always ready.
        for (int i = 0; i < 7; i++) begin
            flush     = vecs[i].flush;
            out_ready = vecs[i].rdy;
            #1;
            chk($sformatf("t1_rd_%0d", i), 32'(fifo_rd_ena), 32'(vecs[i].exp_rd));
            chk($sformatf("t1_vld_%0d", i), 32'(out_valid), 32'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) chk_out($sformatf("t1_%0d", i), vecs[i].exp_data, vecs[i].exp_cnt);
            @(negedge clk);
        end

        // Backpressure: first pack held, second pack fills then stalls in HOLD.
        out_ready = 1'b0;
        base = rd_ptr;
        for (int v = 1; v <= 8; v++) push(4'(v));
        #1;
        wait_valid("t2_first", 12);
        chk_out("t2_first", 16'h4321, 3'd4);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t2_hold_vld_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("t2_hold_data_%0d", k), 32'(out_data), 32'h4321);
        end
        chk("t2_reads", 32'(rd_ptr - base), 32'd8);
        repeat (3) @(negedge clk);
        #1;
        chk("t2_reads_stall", 32'(rd_ptr - base), 32'd8);
        chk_out("t2_stall", 16'h4321, 3'd4);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t2_second_vld", 32'(out_valid), 32'd1);
        chk_out("t2_second", 16'h8765, 3'd4);
        @(negedge clk);
        #1;
        chk("t2_drain_vld", 32'(out_valid), 32'd0);

        // Partial pack emitted by flush after the FIFO runs dry.
        @(negedge clk);
        push(4'h5); push(4'h6);
        repeat (5) @(negedge clk);
        #1;
        chk("t3_stall_vld", 32'(out_valid), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid("t3_flush", 4);
        chk_out("t3_flush", 16'h0065, 3'd2);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t3_empty_flush_vld_%0d", k), 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // Flush coinciding with the read of the third word keeps that word.
        push(4'hA); push(4'hB); push(4'hC); push(4'hD);
        #1;
        chk("t4_rd0", 32'(fifo_rd_ena), 32'd1);
        @(negedge clk);
        #1;
        chk("t4_rd1", 32'(fifo_rd_ena), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("t4_rd2", 32'(fifo_rd_ena), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("t4_rd_blocked", 32'(fifo_rd_ena), 32'd0);
        wait_valid("t4_flush", 4);
        chk_out("t4_flush", 16'h0CBA, 3'd3);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid("t4_tail", 4);
        chk_out("t4_tail", 16'h000D, 3'd1);

        // Asynchronous reset mid-pack with a held output word.
        @(negedge clk);
        out_ready = 1'b0;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        #1;
        wait_valid("t5_pre", 8);
        push(4'h5); push(4'h6);
        repeat (5) @(negedge clk);
        #1;
        chk("t5_held_vld", 32'(out_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("t5_rst_vld", 32'(out_valid), 32'd0);
        chk("t5_rst_rd", 32'(fifo_rd_ena), 32'd0);
        chk_out("t5_rst", 16'h0000, 3'd0);
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        push(4'h9); push(4'hA); push(4'hB); push(4'hC);
        #1;
        wait_valid("t5_post", 10);
        chk_out("t5_post", 16'hCBA9, 3'd4);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
